// File: rtl/pipe_stage_elastic_if.sv
// Handshake bundle for pipe_stage_elastic: upstream accept side, downstream
// pop side, stage flush and occupancy. The stage itself uses the slave view.
interface pipe_stage_elastic_if #(
   parameter int PAYLOAD_W = 160,
   parameter int INSTR_W   = 32,
   parameter int EXC_W     = 5
);
   logic                 Flush;
   logic                 In_Valid;
   logic                 In_Ready;
   logic                 In_Nullify;
   logic [INSTR_W-1:0]   In_Instr;
   logic [PAYLOAD_W-1:0] In_Payload;
   logic                 In_BD;
   logic [EXC_W-1:0]     In_ExcCode;
   logic                 Out_Valid;
   logic                 Out_Ready;
   logic [INSTR_W-1:0]   Out_Instr;
   logic [PAYLOAD_W-1:0] Out_Payload;
   logic                 Out_BD;
   logic [EXC_W-1:0]     Out_ExcCode;
   logic [1:0]           Occupancy;

   modport slave (
      input  Flush, In_Valid, In_Nullify, In_Instr, In_Payload, In_BD, In_ExcCode, Out_Ready,
      output In_Ready, Out_Valid, Out_Instr, Out_Payload, Out_BD, Out_ExcCode, Occupancy
   );

   modport master (
      output Flush, In_Valid, In_Nullify, In_Instr, In_Payload, In_BD, In_ExcCode, Out_Ready,
      input  In_Ready, Out_Valid, Out_Instr, Out_Payload, Out_BD, Out_ExcCode, Occupancy
   );
endinterface

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register with valid/ready handshake, optional skid entry,
// whole-stage flush and per-instruction nullify.
module pipe_stage_elastic #(
   parameter int PAYLOAD_W = 160,
   parameter int INSTR_W   = 32,
   parameter int EXC_W     = 5,
   parameter int SKID      = 1
) (
   input logic                 Clk,
   input logic                 Rst_n,
   pipe_stage_elastic_if.slave bus
);
   typedef struct packed {
      logic [INSTR_W-1:0]   instr;
      logic [PAYLOAD_W-1:0] payload;
      logic                 bd;
      logic [EXC_W-1:0]     exc;
   } entry_t;

   entry_t m_q, m_d, s_q, s_d, in_ent;
   logic   m_v_q, m_v_d, s_v_q, s_v_d;
   logic   in_ready, accept, pop;

   assign in_ent = '{instr:   bus.In_Nullify ? '0 : bus.In_Instr,
                     payload: bus.In_Payload,
                     bd:      bus.In_BD,
                     exc:     bus.In_ExcCode};

   // With a skid entry the ready is purely registered, breaking the
   // combinational ready chain back through the pipeline.
   always_comb begin
      if (!Rst_n)         in_ready = 1'b0;
      else if (SKID != 0) in_ready = !s_v_q;
      else                in_ready = !m_v_q || bus.Out_Ready;
   end

   assign accept = bus.In_Valid && in_ready;
   assign pop    = m_v_q && bus.Out_Ready;

   always_comb begin
      m_d   = m_q;
      m_v_d = m_v_q;
      s_d   = s_q;
      s_v_d = s_v_q;
      if (bus.Flush) begin
         m_d   = '0;
         m_v_d = 1'b0;
         s_d   = '0;
         s_v_d = 1'b0;
      end else if (pop && s_v_q) begin
         m_d   = s_q;
         s_d   = '0;
         s_v_d = 1'b0;
      end else if (pop && accept) begin
         m_d = in_ent;
      end else if (pop) begin
         m_d   = '0;
         m_v_d = 1'b0;
      end else if (accept && !m_v_q) begin
         m_d   = in_ent;
         m_v_d = 1'b1;
      end else if (accept && (SKID != 0)) begin
         s_d   = in_ent;
         s_v_d = 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         m_q   <= '0;
         m_v_q <= 1'b0;
         s_q   <= '0;
         s_v_q <= 1'b0;
      end else begin
         m_q   <= m_d;
         m_v_q <= m_v_d;
         s_q   <= s_d;
         s_v_q <= s_v_d;
      end
   end

   // M fields are zeroed whenever M is empty, so bubbles read as 0.
   assign bus.In_Ready    = in_ready;
   assign bus.Out_Valid   = m_v_q;
   assign bus.Out_Instr   = m_q.instr;
   assign bus.Out_Payload = m_q.payload;
   assign bus.Out_BD      = m_q.bd;
   assign bus.Out_ExcCode = m_q.exc;
   assign bus.Occupancy   = {1'b0, m_v_q} + {1'b0, s_v_q};
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: vector table, corner sequences, and random
// traffic against a FIFO reference for both SKID builds.
module tb_pipe_stage_elastic;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   pipe_stage_elastic_if #(.PAYLOAD_W(160), .INSTR_W(32), .EXC_W(5)) if1 ();
   pipe_stage_elastic_if #(.PAYLOAD_W(160), .INSTR_W(32), .EXC_W(5)) if0 ();

   pipe_stage_elastic #(.PAYLOAD_W(160), .INSTR_W(32), .EXC_W(5), .SKID(1)) u_dut1 (
      .Clk(clk), .Rst_n(rst_n), .bus(if1));
   pipe_stage_elastic #(.PAYLOAD_W(160), .INSTR_W(32), .EXC_W(5), .SKID(0)) u_dut0 (
      .Clk(clk), .Rst_n(rst_n), .bus(if0));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic [31:0]  instr;
      logic [159:0] payload;
      logic         bd;
      logic [4:0]   exc;
   } ent_t;

   typedef struct {
      logic        fl, v, nul, ordy;
      logic [31:0] instr;
      logic        eov;
      logic [31:0] einstr;
      logic [1:0]  eocc;
      logic        erdy;
   } vec_t;

   vec_t tbl[14];
   ent_t q1[$];
   ent_t q0[$];

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drv(input int k, input logic fl, input logic v, input logic nul, input logic ordy,
                      input logic [31:0] instr, input logic [159:0] pl, input logic bd,
                      input logic [4:0] exc);
      if (k == 1) begin
         if1.Flush = fl; if1.In_Valid = v; if1.In_Nullify = nul; if1.Out_Ready = ordy;
         if1.In_Instr = instr; if1.In_Payload = pl; if1.In_BD = bd; if1.In_ExcCode = exc;
      end else begin
         if0.Flush = fl; if0.In_Valid = v; if0.In_Nullify = nul; if0.Out_Ready = ordy;
         if0.In_Instr = instr; if0.In_Payload = pl; if0.In_BD = bd; if0.In_ExcCode = exc;
      end
   endtask

   // Compare a DUT's outputs against the head of its reference queue.
   task automatic cmp_model(input int k);
      ent_t e;
      logic ev;
      int   n;
      if (k == 1) n = q1.size(); else n = q0.size();
      ev = (n > 0);
      e  = '0;
      if (ev) e = (k == 1) ? q1[0] : q0[0];
      if (k == 1) begin
         chk("rand1_ov", if1.Out_Valid, ev);
         chk("rand1_ent", {if1.Out_Instr, if1.Out_Payload, if1.Out_BD, if1.Out_ExcCode}, e);
         chk("rand1_occ", if1.Occupancy, n);
      end else begin
         chk("rand0_ov", if0.Out_Valid, ev);
         chk("rand0_ent", {if0.Out_Instr, if0.Out_Payload, if0.Out_BD, if0.Out_ExcCode}, e);
         chk("rand0_occ", if0.Occupancy, n);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      drv(1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h55, '0, 1'b0, '0);
      drv(0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h55, '0, 1'b0, '0);

      // Reset held two cycles with traffic present
      repeat (2) begin
         @(posedge clk); #1;
         chk("rst_ov", if1.Out_Valid, 1'b0);
         chk("rst_instr", if1.Out_Instr, 32'h0);
         chk("rst_occ", if1.Occupancy, 2'd0);
         chk("rst_rdy1", if1.In_Ready, 1'b0);
         chk("rst_rdy0", if0.In_Ready, 1'b0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drv(1, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0, 1'b0, '0);
      drv(0, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0, 1'b0, '0);
      #1;
      chk("rel_rdy1", if1.In_Ready, 1'b1);
      chk("rel_rdy0", if0.In_Ready, 1'b1);

      // Streaming 1..8 with Out_Ready held high
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         drv(1, 1'b0, 1'b1, 1'b0, 1'b1, i, '0, 1'b0, '0);
         #1 chk("strm_rdy", if1.In_Ready, 1'b1);
         @(posedge clk); #1;
         chk("strm_ov", if1.Out_Valid, 1'b1);
         chk("strm_instr", if1.Out_Instr, i);
      end
      @(negedge clk);
      drv(1, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0, 1'b0, '0);
      @(posedge clk); #1;
      chk("strm_drain", if1.Occupancy, 2'd0);

      // Back-pressure, pop/refill, flush and nullify vectors (SKID=1)
      //          fl    v     nul   ordy  instr  eov   einstr  eocc erdy
      tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'hA, 1'b1, 32'hA,  2'd1, 1'b1};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'hB, 1'b1, 32'hA,  2'd2, 1'b0};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'hC, 1'b1, 32'hA,  2'd2, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'hC, 1'b1, 32'hB,  2'd1, 1'b1};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'hC, 1'b1, 32'hC,  2'd1, 1'b1};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0,  2'd0, 1'b1};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h11, 1'b1, 32'h11, 2'd1, 1'b1};
      tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h12, 1'b1, 32'h11, 2'd2, 1'b0};
      tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'hD, 1'b0, 32'h0,  2'd0, 1'b1};
      tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'hC, 1'b1, 32'h0,  2'd1, 1'b1};
      tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0,  2'd0, 1'b1};
      tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h21, 1'b1, 32'h21, 2'd1, 1'b1};
      tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h21, 2'd1, 1'b1};
      tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h22, 1'b0, 32'h0,  2'd0, 1'b1};
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         drv(1, tbl[i].fl, tbl[i].v, tbl[i].nul, tbl[i].ordy, tbl[i].instr,
             {128'h0, tbl[i].instr}, 1'b0, '0);
         @(posedge clk); #1;
         chk($sformatf("vec%0d_ov", i), if1.Out_Valid, tbl[i].eov);
         chk($sformatf("vec%0d_instr", i), if1.Out_Instr, tbl[i].einstr);
         chk($sformatf("vec%0d_occ", i), if1.Occupancy, tbl[i].eocc);
         chk($sformatf("vec%0d_rdy", i), if1.In_Ready, tbl[i].erdy);
      end

      // Nullify keeps payload, BD and exception code
      @(negedge clk);
      drv(1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_000C, 160'h1234, 1'b1, 5'd10);
      @(posedge clk); #1;
      chk("nul_instr", if1.Out_Instr, 32'h0);
      chk("nul_payload", if1.Out_Payload, 160'h1234);
      chk("nul_exc", if1.Out_ExcCode, 5'd10);
      chk("nul_bd", if1.Out_BD, 1'b1);
      @(negedge clk);
      drv(1, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0, 1'b0, '0);
      @(posedge clk); #1;
      chk("nul_drain_pl", if1.Out_Payload, 160'h0);

      // SKID=0: blocked when full, pop and refill together
      @(negedge clk);
      drv(0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h31, '0, 1'b0, '0);
      @(posedge clk); #1;
      chk("s0_instr_a", if0.Out_Instr, 32'h31);
      chk("s0_occ_a", if0.Occupancy, 2'd1);
      @(negedge clk);
      drv(0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h32, '0, 1'b0, '0);
      #1 chk("s0_rdy_blk", if0.In_Ready, 1'b0);
      @(posedge clk); #1;
      chk("s0_hold", if0.Out_Instr, 32'h31);
      @(negedge clk);
      drv(0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h32, '0, 1'b0, '0);
      #1 chk("s0_rdy_pass", if0.In_Ready, 1'b1);
      @(posedge clk); #1;
      chk("s0_refill", if0.Out_Instr, 32'h32);
      chk("s0_occ_b", if0.Occupancy, 2'd1);
      @(negedge clk);
      drv(0, 1'b1, 1'b0, 1'b0, 1'b1, '0, '0, 1'b0, '0);
      drv(1, 1'b1, 1'b0, 1'b0, 1'b1, '0, '0, 1'b0, '0);
      @(posedge clk); #1;
      chk("s0_flush", if0.Occupancy, 2'd0);

      // Random traffic against FIFO reference models
      q1.delete();
      q0.delete();
      for (int c = 0; c < 400; c++) begin
         logic fl, v, nul, ordy, bd, r1, r0;
         logic [31:0] instr;
         logic [159:0] pl;
         logic [4:0] exc;
         ent_t e;
         @(negedge clk);
         cmp_model(1);
         cmp_model(0);
         fl    = ($urandom_range(0, 19) == 0);
         v     = ($urandom_range(0, 9) < 7);
         nul   = ($urandom_range(0, 4) == 0);
         ordy  = ($urandom_range(0, 9) < 6);
         bd    = $urandom_range(0, 1);
         exc   = $urandom_range(0, 31);
         instr = $urandom;
         pl    = {$urandom, $urandom, $urandom, $urandom, $urandom};
         drv(1, fl, v, nul, ordy, instr, pl, bd, exc);
         drv(0, fl, v, nul, ordy, instr, pl, bd, exc);
         r1 = (q1.size() < 2);
         r0 = (q0.size() == 0) || ordy;
         #1;
         chk("rand1_rdy", if1.In_Ready, r1);
         chk("rand0_rdy", if0.In_Ready, r0);
         @(posedge clk);
         e = '{instr: nul ? 32'h0 : instr, payload: pl, bd: bd, exc: exc};
         if (fl) begin
            q1.delete();
            q0.delete();
         end else begin
            if (q1.size() > 0 && ordy) void'(q1.pop_front());
            if (v && r1) q1.push_back(e);
            if (q0.size() > 0 && ordy) void'(q0.pop_front());
            if (v && r0) q0.push_back(e);
         end
      end

      // Fill, then reset and flush together
      @(negedge clk);
      drv(1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h77, '1, 1'b1, 5'd3);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      drv(1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h78, '1, 1'b1, 5'd3);
      @(posedge clk); #1;
      chk("rstfl_occ", if1.Occupancy, 2'd0);
      chk("rstfl_pl", if1.Out_Payload, 160'h0);
      chk("rstfl_exc", if1.Out_ExcCode, 5'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drv(1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
      #1 chk("rstfl_rdy", if1.In_Ready, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pipe_stage_elastic.md
# pipe_stage_elastic

Parametrised elastic pipeline register placed between two stages of the pipelined CPU, e.g. ID→EX. It succeeds the fixed-width stall/flush stage register with a valid/ready handshake and an optional skid entry, so back-pressure does not need a global combinational stall. It carries the instruction word, a generic payload, the branch-delay flag and an exception code. It also supports whole-stage flush (exception entry/return) and instruction nullify (reserved instruction), where only the instruction is replaced by a NOP.

## Interface
Parameters:
- PAYLOAD_W, 160, width of the opaque payload (operands, immediate, PC, PC+8, destination register).
- INSTR_W, 32, width of the instruction word.
- EXC_W, 5, width of the exception code.
- SKID, 1, 1 = two-entry (main + skid) with registered In_Ready; 0 = single entry with pass-through ready.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Rst_n  in  1  reset; one clock, synchronous, active-low.
- Flush  in  1  discard every held and incoming entry this cycle.
- In_Valid  in  1  upstream entry present.
- In_Ready  out  1  block can accept this cycle.
- In_Nullify  in  1  store the accepted entry with instruction forced to 0.
- In_Instr  in  INSTR_W  instruction word.
- In_Payload  in  PAYLOAD_W  payload.
- In_BD  in  1  branch-delay-slot flag.
- In_ExcCode  in  EXC_W  exception code; 0 = none.
- Out_Valid  out  1  main entry valid.
- Out_Ready  in  1  downstream accepts this cycle.
- Out_Instr, Out_Payload, Out_BD, Out_ExcCode  out  INSTR_W/PAYLOAD_W/1/EXC_W  main entry fields.
- Occupancy  out  2  number of valid entries (0..2; never exceeds 1 when SKID=0).

## Operation
- State: main entry M (valid bit M_v plus fields) and, if SKID=1, skid entry S (S_v plus fields).
- Handshake: accept = In_Valid & In_Ready; pop = Out_Valid & Out_Ready. Out_Valid = M_v.
- In_Ready is 0 whenever Rst_n=0.
  - SKID=1: In_Ready = !S_v, depending only on registered state.
  - SKID=0: In_Ready = !M_v | Out_Ready.
- Bubble convention: when M_v=0, all Out_* data fields read 0. The M field registers are cleared to 0 on pop-without-refill, flush and reset.
- Captured fields: In_Instr, or 0 when In_Nullify=1; In_Payload; In_BD; In_ExcCode. All are unmodified otherwise.
- In_Nullify is ignored unless accept=1.
- Update priority, one per cycle, first match wins:
  1. Rst_n=0: M_v=S_v=0, all fields 0.
  2. Flush=1: same clearing as reset. A concurrently accepted entry is dropped and the pop is not counted.
  3. pop with S_v=1: S→M, S_v=0. accept is impossible because In_Ready=0.
  4. pop with accept, S empty: input→M.
  5. pop only: M_v=0, M fields cleared.
  6. accept with M_v=0: input→M.
  7. accept with M_v=1 and no pop (SKID=1 only): input→S.
  8. Otherwise: hold all state.
- Ordering: entries leave strictly in arrival order. No entry is duplicated or lost except on Flush or reset.
- Occupancy = M_v + S_v.

## Timing
- Reset values: Out_Valid=0, all Out_* = 0, Occupancy=0, In_Ready=0 during reset. In_Ready=1 from the first cycle after Rst_n rises.
- Latency: an entry accepted at edge N appears on Out_* with Out_Valid=1 after edge N, when the block is empty.
- Throughput: 1 entry/cycle sustained while Out_Ready=1, for both SKID values.
- SKID=1 back-pressure: with Out_Ready low, two entries are absorbed. In_Ready falls the cycle after the second accept and rises the cycle after the next pop.
- Full with simultaneous pop and In_Valid (SKID=1): the skid moves to main and the input is not accepted. In_Ready was 0 that cycle.
- Flush is effective at the next edge: Out_Valid=0, Occupancy=0.
- Flush while Out_Ready=1 and Out_Valid=1: downstream sees the pop, but the entry is considered killed. Downstream must also observe Flush.
- Flush and Rst_n=0 in the same cycle: reset dominates, with identical outcome.
- Nullify on a cycle with no accept has no effect. Nullify together with Flush: the entry is dropped.

## Test plan
- Reset: hold Rst_n=0 for 2 cycles with In_Valid=1 → Out_Valid=0, Out_Instr=0, Occupancy=0, In_Ready=0. After release, In_Ready=1.
- Streaming (SKID=1, Out_Ready=1): send instrs 0x1..0x8 back-to-back → Out_Instr shows 0x1..0x8 on consecutive cycles, 1-cycle latency, In_Ready never 0.
- Back-pressure: Out_Ready=0, send 0xA, 0xB, 0xC → 0xA, 0xB accepted, Occupancy=2, In_Ready=0, 0xC held upstream. Raise Out_Ready → outputs 0xA, 0xB, 0xC in order, no loss.
- Flush: Occupancy=2 with Flush=1 and In_Valid=1 (instr 0xD) → next cycle Out_Valid=0, Occupancy=0, 0xD not captured.
- Nullify: accept instr 0x0000_000C, payload 0x1234, ExcCode 10, BD=1, In_Nullify=1 → Out_Instr=0, payload 0x1234, Out_ExcCode=10, Out_BD=1.
- SKID=0 build: Out_Ready=0 with one entry held → In_Ready=0. Out_Ready=1 with In_Valid=1 → pop and refill in the same cycle, Occupancy stays 1.
